drc_frm_seq: RTL and testbench
==============================

// Module: drc_frm_seq
// PURPOSE
//  Frame capture sequencer for DVP RX. It sits between the pixel-info FIFO ({vsync,hsync,byte}, one entry per PCLK sample) and the
//  RGB concat FIFO. It arms on software start and locks to vsync, then forwards active bytes with a frame-last marker. It checks
//  line and frame geometry against the configured width/height and reports completion and error as sticky irq/trap.
// PARAMETERS
//  DVP_DATA_W   8                    DVP byte width
//  PXL_INFO_W   DVP_DATA_W+2         info word: [W-1]=vsync, [W-2]=hsync, [DVP_DATA_W-1:0]=byte
//  IMG_DIM_MAX  640                  max width/height in pixels
//  IMG_DIM_W    $clog2(IMG_DIM_MAX)  dimension field width
// PORTS
//  clk             in   1              single clock
//  rst             in   1              synchronous, active-high reset
//  bwd_pxl_info_dat in  PXL_INFO_W     pixel-info entry
//  bwd_pxl_info_vld in  1              entry valid
//  bwd_pxl_info_rdy out 1              entry accepted when vld&rdy
//  fwd_pxl_dat     out  DVP_DATA_W     active byte to concat FIFO
//  fwd_pxl_last    out  1              last byte of frame
//  fwd_pxl_vld     out  1              byte valid
//  fwd_pxl_rdy     in   1              downstream ready
//  cfg_en          in   1              RX enable
//  cfg_mode        in   2              0=single-shot, 1=continuous, 2/3=single-shot
//  cfg_start       in   1              start pulse
//  cfg_start_qed   out  1              1-cycle ack: start accepted
//  img_width       in   IMG_DIM_W      pixels per line, sampled on start
//  img_height      in   IMG_DIM_W      lines per frame, sampled on start
//  irq_msk_comp    in   1              1 = suppress irq on completion
//  irq_msk_err     in   1              1 = suppress trap on error
//  irq_clr         in   1              clear irq
//  trap_clr        in   1              clear trap
//  rx_state        out  3              current state encoding
//  rx_len          out  2*IMG_DIM_W    completed pixels (byte pairs) in current/last frame
//  irq             out  1              sticky, frame complete
//  trap            out  1              sticky, frame error
// BEHAVIOUR
//  Reset: state=IDLE; all counters, irq, trap, cfg_start_qed, rx_len = 0. fwd_pxl_vld=0 and fwd_pxl_last=0 in every state except ACTIVE.
//  States: IDLE=0, ARMED=1, SYNC=2, ACTIVE=3, DONE=4, ERROR=5.
//  bwd_pxl_info_rdy is 1 in IDLE, ARMED, SYNC, DONE and ERROR; those entries are discarded.
//  IDLE: if cfg_en&cfg_start and width!=0 and height!=0, latch width/height/mode, pulse cfg_start_qed, go to ARMED.
//   Otherwise stay in IDLE. cfg_start outside IDLE is ignored; cfg_start_qed stays 0.
//  ARMED: an accepted entry with vsync=1 moves to SYNC.
//  SYNC: the first accepted entry with vsync=0 moves to ACTIVE. Line/byte counters and rx_len are cleared, and the same entry is
//   processed under the ACTIVE rules in that cycle.
//  ACTIVE, per entry:
//   - hsync=1, vsync=0 (active byte): combinational pass-through, zero latency.
//     fwd_pxl_vld=bwd_pxl_info_vld; bwd_pxl_info_rdy=fwd_pxl_rdy. byte_cnt (IMG_DIM_W+1 bits) increments on handshake.
//     rx_len increments on each odd byte (2nd, 4th, ...).
//   - hsync=0, vsync=0: bwd_pxl_info_rdy=1, nothing forwarded. If the previous accepted entry had hsync=1 (line end):
//     byte_cnt!=2*width -> ERROR; else line_cnt++ and byte_cnt=0.
//   - vsync=1 before completion (short frame) -> ERROR.
//   - Overrun byte (byte_cnt==2*width already) -> not forwarded, consumed, -> ERROR.
//   - fwd_pxl_last=1 with byte where line_cnt==height-1 and byte_cnt==2*width-1; its handshake -> DONE.
//  DONE (1 cycle): set irq unless irq_msk_comp. Continuous -> ARMED, else -> IDLE.
//  ERROR (1 cycle): set trap unless irq_msk_err; no fwd_pxl_last emitted. Continuous -> ARMED, else -> IDLE.
//  cfg_en=0 in any state -> IDLE next cycle. No irq/trap set; in-flight fwd byte is dropped only if not yet handshaken.
//  irq/trap: a set and a clear in the same cycle -> set wins. rx_len holds after DONE/ERROR until the next SYNC->ACTIVE.
// TESTING
//  T1 width=4,height=2,single: start, 3 vsync entries, 2 lines of 8 hsync bytes with 2-entry gaps.
//     -> 16 bytes forwarded, last on 16th, DONE then IDLE, irq=1, rx_len=8.
//  T2 same config, line0 has 6 bytes then hsync=0 -> ERROR, trap=1, irq=0, no fwd_pxl_last.
//  T3 T1 with fwd_pxl_rdy low for 3 cycles mid-line -> bwd_pxl_info_rdy low those cycles, byte order/count intact, irq=1.
//  T4 continuous mode, 2 frames; irq_clr after frame 1
//     -> irq 1,0,1, state returns to ARMED after each DONE, 32 bytes total.
//  T5 cfg_en dropped mid-ACTIVE -> IDLE next cycle, irq=trap=0.
//     cfg_start in ACTIVE -> cfg_start_qed=0. Start with width=0 -> rejected.
//  T6 vsync=1 after 1 line with irq_msk_err=1 -> ERROR for 1 cycle, trap stays 0.
//     trap_clr and error on the same cycle with mask=0 -> trap=1.

Source files
------------

// File: rtl/drc_frm_seq.sv
// DVP RX frame capture sequencer: arms on start, locks to vsync, forwards active bytes with a frame-last marker.
// Checks line/frame geometry against the latched width/height and reports sticky irq (complete) / trap (error).
module drc_frm_seq #(
   parameter int DVP_DATA_W  = 8,
   parameter int PXL_INFO_W  = DVP_DATA_W + 2,
   parameter int IMG_DIM_MAX = 640,
   parameter int IMG_DIM_W   = $clog2(IMG_DIM_MAX)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PXL_INFO_W-1:0]  bwd_pxl_info_dat,
   input  logic                   bwd_pxl_info_vld,
   output logic                   bwd_pxl_info_rdy,
   output logic [DVP_DATA_W-1:0]  fwd_pxl_dat,
   output logic                   fwd_pxl_last,
   output logic                   fwd_pxl_vld,
   input  logic                   fwd_pxl_rdy,
   input  logic                   cfg_en,
   input  logic [1:0]             cfg_mode,
   input  logic                   cfg_start,
   output logic                   cfg_start_qed,
   input  logic [IMG_DIM_W-1:0]   img_width,
   input  logic [IMG_DIM_W-1:0]   img_height,
   input  logic                   irq_msk_comp,
   input  logic                   irq_msk_err,
   input  logic                   irq_clr,
   input  logic                   trap_clr,
   output logic [2:0]             rx_state,
   output logic [2*IMG_DIM_W-1:0] rx_len,
   output logic                   irq,
   output logic                   trap
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARMED  = 3'd1;
   localparam logic [2:0] ST_SYNC   = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   localparam logic [2:0] ST_ERROR  = 3'd5;

   localparam int CNT_W = IMG_DIM_W + 1;
   localparam int LEN_W = 2 * IMG_DIM_W;

   logic [2:0]           state_q, state_d;
   logic [IMG_DIM_W-1:0] width_q, width_d;
   logic [IMG_DIM_W-1:0] height_q, height_d;
   logic [1:0]           mode_q, mode_d;
   logic [IMG_DIM_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
   logic                 prev_hs_q, prev_hs_d;
   logic [LEN_W-1:0]     rx_len_q, rx_len_d;
   logic                 irq_q, irq_d;
   logic                 trap_q, trap_d;
   logic                 start_qed_q, start_qed_d;

   logic                 in_vs;
   logic                 in_hs;
   logic [CNT_W-1:0]     line_bytes;
   logic [CNT_W-1:0]     cur_byte;
   logic [IMG_DIM_W-1:0] cur_line;
   logic                 cur_prev_hs;
   logic [LEN_W-1:0]     cur_len;
   logic                 is_last;
   logic                 irq_set;
   logic                 trap_set;

   assign in_vs       = bwd_pxl_info_dat[PXL_INFO_W-1];
   assign in_hs       = bwd_pxl_info_dat[PXL_INFO_W-2];
   assign fwd_pxl_dat = bwd_pxl_info_dat[DVP_DATA_W-1:0];
   assign line_bytes  = {width_q, 1'b0};

   // SYNC handles its first non-vsync entry as ACTIVE with counters already cleared
   assign cur_byte    = (state_q == ST_SYNC) ? '0   : byte_cnt_q;
   assign cur_line    = (state_q == ST_SYNC) ? '0   : line_cnt_q;
   assign cur_prev_hs = (state_q == ST_SYNC) ? 1'b0 : prev_hs_q;
   assign cur_len     = (state_q == ST_SYNC) ? '0   : rx_len_q;
   assign is_last     = (cur_line == height_q - 1'b1) && (cur_byte == line_bytes - 1'b1);

   always_comb begin
      state_d          = state_q;
      width_d          = width_q;
      height_d         = height_q;
      mode_d           = mode_q;
      line_cnt_d       = line_cnt_q;
      byte_cnt_d       = byte_cnt_q;
      prev_hs_d        = prev_hs_q;
      rx_len_d         = rx_len_q;
      start_qed_d      = 1'b0;
      irq_set          = 1'b0;
      trap_set         = 1'b0;
      fwd_pxl_vld      = 1'b0;
      fwd_pxl_last     = 1'b0;
      bwd_pxl_info_rdy = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (cfg_en && cfg_start && (img_width != '0) && (img_height != '0)) begin
               width_d     = img_width;
               height_d    = img_height;
               mode_d      = cfg_mode;
               start_qed_d = 1'b1;
               state_d     = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (bwd_pxl_info_vld && in_vs)
               state_d = ST_SYNC;
         end
         ST_SYNC, ST_ACTIVE: begin
            if (bwd_pxl_info_vld && !(state_q == ST_SYNC && in_vs)) begin
               if (in_vs) begin
                  state_d = ST_ERROR;
               end else if (in_hs) begin
                  if (cur_byte == line_bytes) begin
                     // overrun byte is swallowed rather than forwarded
                     state_d = ST_ERROR;
                  end else begin
                     fwd_pxl_vld      = 1'b1;
                     fwd_pxl_last     = is_last;
                     bwd_pxl_info_rdy = fwd_pxl_rdy;
                     if (fwd_pxl_rdy) begin
                        byte_cnt_d = cur_byte + 1'b1;
                        line_cnt_d = cur_line;
                        prev_hs_d  = 1'b1;
                        rx_len_d   = cur_len + LEN_W'(cur_byte[0]);
                        state_d    = is_last ? ST_DONE : ST_ACTIVE;
                     end
                  end
               end else begin
                  byte_cnt_d = cur_byte;
                  line_cnt_d = cur_line;
                  rx_len_d   = cur_len;
                  prev_hs_d  = 1'b0;
                  state_d    = ST_ACTIVE;
                  if (cur_prev_hs) begin
                     if (cur_byte != line_bytes) begin
                        state_d = ST_ERROR;
                     end else begin
                        line_cnt_d = cur_line + 1'b1;
                        byte_cnt_d = '0;
                     end
                  end
               end
            end
         end
         ST_DONE: begin
            irq_set = !irq_msk_comp;
            state_d = (mode_q == 2'd1) ? ST_ARMED : ST_IDLE;
         end
         ST_ERROR: begin
            trap_set = !irq_msk_err;
            state_d  = (mode_q == 2'd1) ? ST_ARMED : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!cfg_en) begin
         state_d  = ST_IDLE;
         irq_set  = 1'b0;
         trap_set = 1'b0;
      end

      irq_d  = irq_set  | (irq_q  & ~irq_clr);
      trap_d = trap_set | (trap_q & ~trap_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         width_q     <= '0;
         height_q    <= '0;
         mode_q      <= '0;
         line_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         prev_hs_q   <= 1'b0;
         rx_len_q    <= '0;
         irq_q       <= 1'b0;
         trap_q      <= 1'b0;
         start_qed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         mode_q      <= mode_d;
         line_cnt_q  <= line_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         prev_hs_q   <= prev_hs_d;
         rx_len_q    <= rx_len_d;
         irq_q       <= irq_d;
         trap_q      <= trap_d;
         start_qed_q <= start_qed_d;
      end
   end

   assign rx_state      = state_q;
   assign rx_len        = rx_len_q;
   assign irq           = irq_q;
   assign trap          = trap_q;
   assign cfg_start_qed = start_qed_q;

endmodule

// File: tb/tb_drc_frm_seq.sv
// Directed bench for drc_frm_seq: frame capture, geometry errors, backpressure, continuous mode, enable/start corner cases.
module tb_drc_frm_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  bwd_pxl_info_dat;
   logic        bwd_pxl_info_vld;
   logic        bwd_pxl_info_rdy;
   logic [7:0]  fwd_pxl_dat;
   logic        fwd_pxl_last;
   logic        fwd_pxl_vld;
   logic        fwd_pxl_rdy;
   logic        cfg_en;
   logic [1:0]  cfg_mode;
   logic        cfg_start;
   logic        cfg_start_qed;
   logic [9:0]  img_width;
   logic [9:0]  img_height;
   logic        irq_msk_comp;
   logic        irq_msk_err;
   logic        irq_clr;
   logic        trap_clr;
   logic [2:0]  rx_state;
   logic [19:0] rx_len;
   logic        irq;
   logic        trap;

   int total = 0;
   int bad   = 0;
   int fwd_cnt, last_cnt, last_at, ord_err, stall_n;
   logic [7:0] exp_b, tx_b;
   logic [2:0] st_last;

   drc_frm_seq dut (
      .clk(clk), .rst(rst),
      .bwd_pxl_info_dat(bwd_pxl_info_dat), .bwd_pxl_info_vld(bwd_pxl_info_vld), .bwd_pxl_info_rdy(bwd_pxl_info_rdy),
      .fwd_pxl_dat(fwd_pxl_dat), .fwd_pxl_last(fwd_pxl_last), .fwd_pxl_vld(fwd_pxl_vld), .fwd_pxl_rdy(fwd_pxl_rdy),
      .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_start_qed(cfg_start_qed),
      .img_width(img_width), .img_height(img_height),
      .irq_msk_comp(irq_msk_comp), .irq_msk_err(irq_msk_err), .irq_clr(irq_clr), .trap_clr(trap_clr),
      .rx_state(rx_state), .rx_len(rx_len), .irq(irq), .trap(trap)
   );

   always #5 clk = ~clk;

   // forwarded-byte monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (fwd_pxl_vld && fwd_pxl_rdy) begin
         if (fwd_pxl_dat != exp_b) ord_err++;
         exp_b = exp_b + 8'd1;
         fwd_cnt++;
         if (fwd_pxl_last) begin
            last_cnt++;
            last_at = fwd_cnt;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      fwd_cnt  = 0;
      last_cnt = 0;
      last_at  = 0;
      ord_err  = 0;
      exp_b    = 8'd0;
      tx_b     = 8'd0;
   endtask

   task automatic send(input logic vs, input logic hs, input logic [7:0] b);
      int n;
      bwd_pxl_info_dat = {vs, hs, b};
      bwd_pxl_info_vld = 1'b1;
      if (stall_n > 0) begin
         fwd_pxl_rdy = 1'b0;
         for (int i = 0; i < stall_n; i++) begin
            @(negedge clk);
            chk("stall_bwd_rdy", 32'(bwd_pxl_info_rdy), 32'd0);
            tick();
         end
         fwd_pxl_rdy = 1'b1;
         stall_n = 0;
      end
      n = 0;
      @(negedge clk);
      while (!bwd_pxl_info_rdy && n < 20) begin
         tick();
         @(negedge clk);
         n++;
      end
      if (!bwd_pxl_info_rdy) chk("send_accept", 32'(bwd_pxl_info_rdy), 32'd1);
      tick();
      bwd_pxl_info_vld = 1'b0;
   endtask

   task automatic start(input int w, input int h, input logic [1:0] mode);
      img_width  = 10'(w);
      img_height = 10'(h);
      cfg_mode   = mode;
      cfg_start  = 1'b1;
      tick();
      cfg_start  = 1'b0;
   endtask

   task automatic frame(input int w, input int h, input int stall_at);
      repeat (3) send(1'b1, 1'b0, 8'd0);
      for (int l = 0; l < h; l++) begin
         for (int k = 0; k < 2 * w; k++) begin
            if (l == 0 && k == stall_at) stall_n = 3;
            send(1'b0, 1'b1, tx_b);
            tx_b = tx_b + 8'd1;
            if (l == h - 1 && k == 2 * w - 1) st_last = rx_state;
         end
         repeat (2) send(1'b0, 1'b0, 8'd0);
      end
   endtask

   task automatic pulse_irq_clr();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_en = 1'b1; cfg_mode = 2'd0; cfg_start = 1'b0;
      img_width = 10'd4; img_height = 10'd2;
      irq_msk_comp = 1'b0; irq_msk_err = 1'b0; irq_clr = 1'b0; trap_clr = 1'b0;
      bwd_pxl_info_dat = '0; bwd_pxl_info_vld = 1'b0; fwd_pxl_rdy = 1'b1;
      stall_n = 0; st_last = 3'd0;
      clr_mon();
      repeat (3) tick();
      chk("rst_state", 32'(rx_state), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_len", 32'(rx_len), 32'd0);
      chk("rst_qed", 32'(cfg_start_qed), 32'd0);
      chk("rst_fvld", 32'(fwd_pxl_vld), 32'd0);
      chk("rst_brdy", 32'(bwd_pxl_info_rdy), 32'd1);
      rst = 1'b0;
      tick();

      // T1: 4x2 single shot
      clr_mon();
      start(4, 2, 2'd0);
      chk("t1_qed", 32'(cfg_start_qed), 32'd1);
      chk("t1_armed", 32'(rx_state), 32'd1);
      tick();
      chk("t1_qed_pulse", 32'(cfg_start_qed), 32'd0);
      frame(4, 2, -1);
      chk("t1_fwd_cnt", 32'(fwd_cnt), 32'd16);
      chk("t1_last_cnt", 32'(last_cnt), 32'd1);
      chk("t1_last_at", 32'(last_at), 32'd16);
      chk("t1_order", 32'(ord_err), 32'd0);
      chk("t1_done", 32'(st_last), 32'd4);
      chk("t1_idle", 32'(rx_state), 32'd0);
      chk("t1_irq", 32'(irq), 32'd1);
      chk("t1_trap", 32'(trap), 32'd0);
      chk("t1_len", 32'(rx_len), 32'd8);
      pulse_irq_clr();
      chk("t1_irq_clr", 32'(irq), 32'd0);

      // T2: short first line
      clr_mon();
      start(4, 2, 2'd0);
      repeat (3) send(1'b1, 1'b0, 8'd0);
      for (int k = 0; k < 6; k++) begin
         send(1'b0, 1'b1, tx_b);
         tx_b = tx_b + 8'd1;
      end
      send(1'b0, 1'b0, 8'd0);
      chk("t2_error", 32'(rx_state), 32'd5);
      tick();
      chk("t2_idle", 32'(rx_state), 32'd0);
      chk("t2_trap", 32'(trap), 32'd1);
      chk("t2_irq", 32'(irq), 32'd0);
      chk("t2_no_last", 32'(last_cnt), 32'd0);
      chk("t2_fwd_cnt", 32'(fwd_cnt), 32'd6);
      chk("t2_len", 32'(rx_len), 32'd3);
      trap_clr = 1'b1;
      tick();
      trap_clr = 1'b0;
      chk("t2_trap_clr", 32'(trap), 32'd0);

      // T3: downstream stall mid-line
      clr_mon();
      start(4, 2, 2'd0);
      frame(4, 2, 3);
      chk("t3_fwd_cnt", 32'(fwd_cnt), 32'd16);
      chk("t3_order", 32'(ord_err), 32'd0);
      chk("t3_last_at", 32'(last_at), 32'd16);
      chk("t3_irq", 32'(irq), 32'd1);
      pulse_irq_clr();

      // T4: continuous, two frames
      clr_mon();
      start(4, 2, 2'd1);
      frame(4, 2, -1);
      chk("t4_f1_done", 32'(st_last), 32'd4);
      chk("t4_f1_armed", 32'(rx_state), 32'd1);
      chk("t4_f1_irq", 32'(irq), 32'd1);
      pulse_irq_clr();
      chk("t4_irq_clr", 32'(irq), 32'd0);
      frame(4, 2, -1);
      chk("t4_f2_armed", 32'(rx_state), 32'd1);
      chk("t4_f2_irq", 32'(irq), 32'd1);
      chk("t4_fwd_cnt", 32'(fwd_cnt), 32'd32);
      chk("t4_last_cnt", 32'(last_cnt), 32'd2);
      chk("t4_order", 32'(ord_err), 32'd0);
      cfg_en = 1'b0;
      tick();
      cfg_en = 1'b1;
      chk("t4_dis_idle", 32'(rx_state), 32'd0);
      pulse_irq_clr();

      // T5: disable mid-frame, start while busy, zero width
      clr_mon();
      start(4, 2, 2'd0);
      repeat (3) send(1'b1, 1'b0, 8'd0);
      for (int k = 0; k < 3; k++) begin
         send(1'b0, 1'b1, tx_b);
         tx_b = tx_b + 8'd1;
      end
      chk("t5_active", 32'(rx_state), 32'd3);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("t5_busy_qed", 32'(cfg_start_qed), 32'd0);
      chk("t5_still_act", 32'(rx_state), 32'd3);
      cfg_en = 1'b0;
      tick();
      cfg_en = 1'b1;
      chk("t5_dis_idle", 32'(rx_state), 32'd0);
      chk("t5_irq", 32'(irq), 32'd0);
      chk("t5_trap", 32'(trap), 32'd0);
      start(0, 2, 2'd0);
      chk("t5_w0_qed", 32'(cfg_start_qed), 32'd0);
      chk("t5_w0_idle", 32'(rx_state), 32'd0);

      // T6: short frame with trap masked, then clear colliding with error
      clr_mon();
      irq_msk_err = 1'b1;
      start(4, 2, 2'd0);
      repeat (3) send(1'b1, 1'b0, 8'd0);
      for (int k = 0; k < 8; k++) begin
         send(1'b0, 1'b1, tx_b);
         tx_b = tx_b + 8'd1;
      end
      repeat (2) send(1'b0, 1'b0, 8'd0);
      send(1'b1, 1'b0, 8'd0);
      chk("t6_error", 32'(rx_state), 32'd5);
      tick();
      chk("t6_idle", 32'(rx_state), 32'd0);
      chk("t6_trap_msk", 32'(trap), 32'd0);
      chk("t6_len", 32'(rx_len), 32'd4);
      irq_msk_err = 1'b0;
      start(4, 2, 2'd0);
      repeat (3) send(1'b1, 1'b0, 8'd0);
      for (int k = 0; k < 2; k++) begin
         send(1'b0, 1'b1, tx_b);
         tx_b = tx_b + 8'd1;
      end
      send(1'b1, 1'b0, 8'd0);
      chk("t6_error2", 32'(rx_state), 32'd5);
      trap_clr = 1'b1;
      tick();
      trap_clr = 1'b0;
      chk("t6_set_wins", 32'(trap), 32'd1);
      chk("t6_idle2", 32'(rx_state), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
